// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
package video_timing_pkg;

  // Sync polarity encodings (asserted level of hs/vs).
  localparam int unsigned ACTIVE_LOW  = 0;
  localparam int unsigned ACTIVE_HIGH = 1;

  // Default 640x480@60 timing.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  // Full period of one axis (sync, back, active, front in that order).
  function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned act, input int unsigned front);
    return sync + back + act + front;
  endfunction

  // First active position of one axis.
  function automatic int unsigned axis_start(input int unsigned sync, input int unsigned back);
    return sync + back;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: mod-TOTAL counter with enable/resync, plus window decode on its next value.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL  = axis_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT),
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned ACT_LO = axis_start(DEF_H_SYNC, DEF_H_BACK),
  parameter int unsigned ACT_HI = axis_start(DEF_H_SYNC, DEF_H_BACK) + DEF_H_ACTIVE - 1,
  parameter int unsigned CNT_W  = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output logic             wrap_c,
  output logic             sync_c,
  output logic             act_c
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_L = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] LO_L   = CNT_W'(ACT_LO);
  localparam logic [CNT_W-1:0] HI_L   = CNT_W'(ACT_HI);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  // Next count and window decode; out-of-range counts fold back to 0.
  always_comb begin
    at_last   = (cnt >= LAST);
    wrap_c    = en && !resync && at_last;
    cnt_nxt_c = cnt;
    if (resync) begin
      cnt_nxt_c = '0;
    end else if (en) begin
      cnt_nxt_c = at_last ? '0 : cnt + CNT_W'(1);
    end
    sync_c = (cnt_nxt_c < SYNC_L);
    act_c  = (cnt_nxt_c >= LO_L) && (cnt_nxt_c <= HI_L);
  end

  // Counter register; reset parks on the last position so the first enable enters 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with registered sync/blank/request/coordinate outputs.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned HS_POL   = ACTIVE_LOW,
  parameter int unsigned VS_POL   = ACTIVE_LOW,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CNT_W    = 13,
  parameter int unsigned FC_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  output logic             hs,
  output logic             vs,
  output logic             blank_n,
  output logic             active,
  output logic             read_req,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int unsigned H_TOTAL = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned V_TOTAL = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int unsigned H_START = axis_start(H_SYNC, H_BACK);
  localparam int unsigned V_START = axis_start(V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_START_L = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_L = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] REQ_LO_L  = CNT_W'(H_START - REQ_LEAD);
  localparam logic [CNT_W-1:0] REQ_HI_L  = CNT_W'(H_START + H_ACTIVE - 1 - REQ_LEAD);
  localparam logic             HS_ON     = (HS_POL != 0);
  localparam logic             VS_ON     = (VS_POL != 0);

  logic             rs_c;
  logic [CNT_W-1:0] h_nxt_c;
  logic [CNT_W-1:0] v_nxt_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             h_sync_c;
  logic             v_sync_c;
  logic             h_act_c;
  logic             v_act_c;
  logic             act_c;
  logic             req_c;
  logic             line_c;
  logic             frame_c;
  logic             act_q;

  assign rs_c = enable && resync;

  video_timing_axis #(
    .TOTAL  (H_TOTAL),
    .SYNC   (H_SYNC),
    .ACT_LO (H_START),
    .ACT_HI (H_START + H_ACTIVE - 1),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .en        (enable),
    .resync    (rs_c),
    .cnt_nxt_c (h_nxt_c),
    .wrap_c    (h_wrap_c),
    .sync_c    (h_sync_c),
    .act_c     (h_act_c)
  );

  video_timing_axis #(
    .TOTAL  (V_TOTAL),
    .SYNC   (V_SYNC),
    .ACT_LO (V_START),
    .ACT_HI (V_START + V_ACTIVE - 1),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .en        (h_wrap_c),
    .resync    (rs_c),
    .cnt_nxt_c (v_nxt_c),
    .wrap_c    (v_wrap_c),
    .sync_c    (v_sync_c),
    .act_c     (v_act_c)
  );

  // Combined decode of the next raster position; (0,0) is entered only by v wrap or resync.
  always_comb begin
    act_c   = h_act_c && v_act_c;
    req_c   = (h_nxt_c >= REQ_LO_L) && (h_nxt_c <= REQ_HI_L) && v_act_c;
    line_c  = h_wrap_c || rs_c;
    frame_c = v_wrap_c || rs_c;
  end

  // Output registers: update on enabled cycles, hold otherwise, strobes cleared when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      act_q       <= 1'b0;
      read_req    <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      hs          <= h_sync_c ? HS_ON : ~HS_ON;
      vs          <= v_sync_c ? VS_ON : ~VS_ON;
      act_q       <= act_c;
      read_req    <= req_c;
      col         <= act_c ? h_nxt_c - H_START_L : '0;
      row         <= act_c ? v_nxt_c - V_START_L : '0;
      line_start  <= line_c;
      frame_start <= frame_c;
      if (frame_c) begin
        frame_count <= frame_count + FC_W'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign blank_n = act_q;
  assign active  = act_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster and a position-level reference model.
module tb_video_timing_gen;

  localparam int unsigned HA   = 8;
  localparam int unsigned HF   = 2;
  localparam int unsigned HSY  = 3;
  localparam int unsigned HB   = 2;
  localparam int unsigned VA   = 4;
  localparam int unsigned VF   = 1;
  localparam int unsigned VSY  = 2;
  localparam int unsigned VB   = 1;
  localparam int unsigned LEAD = 3;
  localparam int unsigned CW   = 10;
  localparam int unsigned FCW  = 4;
  localparam int unsigned HPOL = 1;
  localparam int unsigned VPOL = 0;

  localparam int HT = HSY + HB + HA + HF;
  localparam int VT = VSY + VB + VA + VF;
  localparam int HS0 = HSY + HB;
  localparam int VS0 = VSY + VB;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          resync;
  logic          hs, vs, blank_n, active, read_req, line_start, frame_start;
  logic [CW-1:0] col, row;
  logic [FCW-1:0] frame_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state: raster position, frame count and expected outputs.
  int m_h, m_v, m_fc;
  int e_hs, e_vs, e_act, e_req, e_col, e_row, e_ls, e_fs;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HSY), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VSY), .V_BACK (VB),
    .HS_POL (HPOL), .VS_POL (VPOL), .REQ_LEAD (LEAD),
    .CNT_W (CW), .FC_W (FCW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .resync      (resync),
    .hs          (hs),
    .vs          (vs),
    .blank_n     (blank_n),
    .active      (active),
    .read_req    (read_req),
    .col         (col),
    .row         (row),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_h = HT - 1; m_v = VT - 1; m_fc = 0;
    e_hs = (HPOL != 0) ? 0 : 1;
    e_vs = (VPOL != 0) ? 0 : 1;
    e_act = 0; e_req = 0; e_col = 0; e_row = 0; e_ls = 0; e_fs = 0;
  endfunction

  // Decode expected outputs from the current model position.
  function automatic void model_decode();
    bit v_in, h_in, r_in;
    v_in  = (m_v >= VS0) && (m_v <= VS0 + VA - 1);
    h_in  = (m_h >= HS0) && (m_h <= HS0 + HA - 1);
    r_in  = (m_h >= HS0 - LEAD) && (m_h <= HS0 + HA - 1 - LEAD);
    e_hs  = (m_h < HSY) ? int'(HPOL) : int'(HPOL == 0);
    e_vs  = (m_v < VSY) ? int'(VPOL) : int'(VPOL == 0);
    e_act = int'(h_in && v_in);
    e_req = int'(r_in && v_in);
    e_col = e_act != 0 ? m_h - HS0 : 0;
    e_row = e_act != 0 ? m_v - VS0 : 0;
  endfunction

  function automatic void model_step(input bit en, input bit rs);
    if (!en) begin
      e_ls = 0; e_fs = 0;
      return;
    end
    if (rs) begin
      m_h = 0; m_v = 0;
    end else begin
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
    e_ls = int'(m_h == 0);
    e_fs = int'(m_h == 0 && m_v == 0);
    if (e_fs != 0) m_fc = (m_fc + 1) % (1 << FCW);
    model_decode();
  endfunction

  task automatic check_all();
    chk("hs", int'(hs), e_hs);
    chk("vs", int'(vs), e_vs);
    chk("blank_n", int'(blank_n), e_act);
    chk("active", int'(active), e_act);
    chk("read_req", int'(read_req), e_req);
    chk("col", int'(col), e_col);
    chk("row", int'(row), e_row);
    chk("line_start", int'(line_start), e_ls);
    chk("frame_start", int'(frame_start), e_fs);
    chk("frame_count", int'(frame_count), m_fc);
  endtask

  task automatic cycle(input bit en, input bit rs);
    enable = en;
    resync = rs;
    @(posedge clk);
    #1;
    model_step(en, rs);
    check_all();
  endtask

  initial begin
    int  since, reqs, lines_req;
    bit  seen, found, en_t, line_has_req;

    reset = 1'b1; enable = 1'b0; resync = 1'b0;
    #3;
    model_reset();
    check_all();
    #10 reset = 1'b0;

    // First enabled cycle enters (0,0).
    cycle(1'b1, 1'b0);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_line_start", int'(line_start), 1);
    chk("first_frame_count", int'(frame_count), 1);
    chk("first_hs_asserted", int'(hs), int'(HPOL));
    chk("first_vs_asserted", int'(vs), int'(VPOL));

    // One continuous frame: period, request total and request lines.
    since = 0; reqs = 0; lines_req = 0; line_has_req = 0; seen = 0;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      cycle(1'b1, 1'b0);
      since++;
      if (line_start && line_has_req) begin lines_req++; line_has_req = 0; end
      if (read_req) begin reqs++; line_has_req = 1; end
      seen = frame_start;
    end
    chk("frame_period", since, FT);
    chk("req_cycles_per_frame", reqs, HA * VA);
    chk("req_lines_per_frame", lines_req, VA);

    // Alternating enable doubles the frame period.
    since = 0; seen = 0; en_t = 0;
    for (int i = 0; i < 4 * FT && !seen; i++) begin
      cycle(en_t, 1'b0);
      en_t = ~en_t;
      since++;
      seen = frame_start;
    end
    chk("toggle_frame_period", since, 2 * FT);

    // Resync mid-frame.
    found = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      cycle(1'b1, 1'b0);
      found = (m_h == HS0 + 4) && (m_v == VS0 + 1);
    end
    chk("reach_resync_point", int'(found), 1);
    cycle(1'b1, 1'b1);
    chk("resync_frame_start", int'(frame_start), 1);
    cycle(1'b0, 1'b1);
    chk("resync_ignored_disabled", int'(frame_start), 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    since = 0; seen = 0;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      cycle(1'b1, 1'b0);
      since++;
      seen = frame_start;
    end
    chk("post_resync_period", since, FT);

    // Randomized enable/resync traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset inside the active area.
    found = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      cycle(1'b1, 1'b0);
      found = (e_act != 0) && (m_h > HS0);
    end
    chk("reach_active_area", int'(found), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    cycle(1'b1, 1'b0);
    chk("restart_frame_start", int'(frame_start), 1);
    for (int i = 0; i < 2 * HT; i++) cycle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
